// File: rtl/hs_bus_amba_axilite_slice_pkg.sv
// Shared types and payload-width helpers for the AXI5-Lite register slice.
// Payload layout of every channel is MSB-first in the order of its *_field_e enum.
package hs_bus_amba_axilite_slice_pkg;

    typedef enum logic [1:0] {
        SLICE_BYPASS,
        SLICE_FWD,
        SLICE_FULL,
        SLICE_HALF
    } slice_mode_e;

    typedef enum logic [1:0] {
        FILL_EMPTY,
        FILL_ONE,
        FILL_TWO
    } fill_state_e;

    localparam int PROT_WIDTH = 3;

    typedef enum int {AX_F_ID, AX_F_ADDR, AX_F_PROT, AX_F_SUBSYSID} ax_field_e;
    typedef enum int {W_F_DATA, W_F_STRB, W_F_USER} w_field_e;
    typedef enum int {B_F_ID, B_F_RESP, B_F_USER} b_field_e;
    typedef enum int {R_F_ID, R_F_DATA, R_F_RESP, R_F_USER_DATA, R_F_USER_RESP} r_field_e;

    function automatic int ax_pld_w(int id_w, int addr_w, int subsysid_w);
        return id_w + addr_w + PROT_WIDTH + subsysid_w;
    endfunction

    function automatic int w_pld_w(int data_w, int user_data_w);
        return data_w + data_w / 8 + user_data_w;
    endfunction

    function automatic int b_pld_w(int id_w, int bresp_w, int user_resp_w);
        return id_w + bresp_w + user_resp_w;
    endfunction

    function automatic int r_pld_w(int id_w, int data_w, int rresp_w, int user_data_w, int user_resp_w);
        return id_w + data_w + rresp_w + user_data_w + user_resp_w;
    endfunction

endpackage

// File: rtl/hs_bus_amba_slice_chan.sv
// One valid/ready pipeline stage in BYPASS, FWD, FULL (2-entry skid) or HALF form.
// Protocol assertions are compiled only with HS_AXILITE_SLICE_ASSERT_EN defined.
module hs_bus_amba_slice_chan
    import hs_bus_amba_axilite_slice_pkg::*;
#(
    parameter slice_mode_e MODE  = SLICE_FULL,
    parameter int          PLD_W = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PLD_W-1:0] in_pld,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PLD_W-1:0] out_pld,
    output logic             empty
);

    if (MODE == SLICE_BYPASS) begin : g_bypass
        wire unused_bypass_clk = aclk;
        assign out_valid = in_valid & aresetn;
        assign in_ready  = out_ready & aresetn;
        assign out_pld   = in_pld;
        assign empty     = 1'b1;
    end else if (MODE == SLICE_FWD) begin : g_fwd
        logic             full_q;
        logic [PLD_W-1:0] pld_q;
        logic             push;

        assign in_ready = !full_q || out_ready;
        assign push     = in_valid && in_ready;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)       full_q <= 1'b0;
            else if (push)      full_q <= 1'b1;
            else if (out_ready) full_q <= 1'b0;
        end

        // NOTE: payload storage has no reset; the occupancy flag alone qualifies it.
        always_ff @(posedge aclk) begin
            if (push) pld_q <= in_pld;
        end

        assign out_valid = full_q;
        assign out_pld   = pld_q;
        assign empty     = !full_q;
    end else if (MODE == SLICE_HALF) begin : g_half
        logic             full_q;
        logic             rdy_q;
        logic [PLD_W-1:0] pld_q;
        logic             push;
        logic             pop;
        logic             full_d;

        assign push   = in_valid && rdy_q;
        assign pop    = full_q && out_ready;
        assign full_d = push || (full_q && !pop);

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                full_q <= 1'b0;
                rdy_q  <= 1'b0;
            end else begin
                full_q <= full_d;
                rdy_q  <= !full_d;
            end
        end

        always_ff @(posedge aclk) begin
            if (push) pld_q <= in_pld;
        end

        assign in_ready  = rdy_q;
        assign out_valid = full_q;
        assign out_pld   = pld_q;
        assign empty     = !full_q;
    end else begin : g_full
        fill_state_e      state_q, state_d;
        logic             rdy_q, vld_q;
        logic [PLD_W-1:0] head_q, skid_q;
        logic             push, pop;
        logic             load_head, head_from_skid, load_skid;

        assign push = in_valid && rdy_q;
        assign pop  = vld_q && out_ready;

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        always_comb begin
            state_d        = state_q;
            load_head      = 1'b0;
            head_from_skid = 1'b0;
            load_skid      = 1'b0;
            case (state_q)
                FILL_EMPTY: begin
                    if (push) begin
                        state_d   = FILL_ONE;
                        load_head = 1'b1;
                    end
                end
                FILL_ONE: begin
                    if (push && !pop) begin
                        state_d   = FILL_TWO;
                        load_skid = 1'b1;
                    end else if (push && pop) begin
                        load_head = 1'b1;
                    end else if (pop) begin
                        state_d = FILL_EMPTY;
                    end
                end
                FILL_TWO: begin
                    if (pop) begin
                        state_d        = FILL_ONE;
                        load_head      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = FILL_EMPTY;
            endcase
        end

        // Ready and valid are flopped copies of the next-state decode to keep outputs registered.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                state_q <= FILL_EMPTY;
                rdy_q   <= 1'b0;
                vld_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rdy_q   <= (state_d != FILL_TWO);
                vld_q   <= (state_d != FILL_EMPTY);
            end
        end

        always_ff @(posedge aclk) begin
            if (load_head) head_q <= head_from_skid ? skid_q : in_pld;
            if (load_skid) skid_q <= in_pld;
        end

        assign in_ready  = rdy_q;
        assign out_valid = vld_q;
        assign out_pld   = head_q;
        assign empty     = (state_q == FILL_EMPTY);
    end

`ifdef HS_AXILITE_SLICE_ASSERT_EN
    if (MODE != SLICE_BYPASS && MODE != SLICE_FWD && MODE != SLICE_FULL && MODE != SLICE_HALF) begin : g_bad_mode
        $error("hs_bus_amba_slice_chan: illegal MODE");
    end

    property p_valid_hold(logic v, logic r);
        @(posedge aclk) disable iff (!aresetn) v && !r |=> v;
    endproperty

    property p_pld_stable(logic v, logic r, logic [PLD_W-1:0] p);
        @(posedge aclk) disable iff (!aresetn) v && !r |=> $stable(p);
    endproperty

    a_in_valid_hold:  assert property (p_valid_hold(in_valid, in_ready));
    a_in_pld_stable:  assert property (p_pld_stable(in_valid, in_ready, in_pld));
    a_out_valid_hold: assert property (p_valid_hold(out_valid, out_ready));
    a_out_pld_stable: assert property (p_pld_stable(out_valid, out_ready, out_pld));
    c_handshake:      cover property (@(posedge aclk) disable iff (!aresetn) out_valid && out_ready);
`endif

endmodule

// File: rtl/hs_bus_amba_axilite_slice.sv
// AXI5-Lite register slice: one configurable stage per channel, requests s->m, responses m->s.
// Optional protocol checking is enabled by defining HS_AXILITE_SLICE_ASSERT_EN.
module hs_bus_amba_axilite_slice
    import hs_bus_amba_axilite_slice_pkg::*;
#(
    parameter int          ID_W_WIDTH      = 1,
    parameter int          ID_R_WIDTH      = 1,
    parameter int          ADDR_WIDTH      = 32,
    parameter int          DATA_WIDTH      = 32,
    parameter int          USER_DATA_WIDTH = 1,
    parameter int          USER_RESP_WIDTH = 1,
    parameter int          SUBSYSID_WIDTH  = 3,
    parameter int          BRESP_WIDTH     = 2,
    parameter int          RRESP_WIDTH     = 2,
    parameter slice_mode_e AW_MODE         = SLICE_FULL,
    parameter slice_mode_e W_MODE          = SLICE_FULL,
    parameter slice_mode_e B_MODE          = SLICE_FWD,
    parameter slice_mode_e AR_MODE         = SLICE_FULL,
    parameter slice_mode_e R_MODE          = SLICE_FWD,
    localparam int AW_PLD_W = ax_pld_w(ID_W_WIDTH, ADDR_WIDTH, SUBSYSID_WIDTH),
    localparam int W_PLD_W  = w_pld_w(DATA_WIDTH, USER_DATA_WIDTH),
    localparam int B_PLD_W  = b_pld_w(ID_W_WIDTH, BRESP_WIDTH, USER_RESP_WIDTH),
    localparam int AR_PLD_W = ax_pld_w(ID_R_WIDTH, ADDR_WIDTH, SUBSYSID_WIDTH),
    localparam int R_PLD_W  = r_pld_w(ID_R_WIDTH, DATA_WIDTH, RRESP_WIDTH, USER_DATA_WIDTH, USER_RESP_WIDTH)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [AW_PLD_W-1:0] s_awpld,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [AW_PLD_W-1:0] m_awpld,
    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [W_PLD_W-1:0]  s_wpld,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [W_PLD_W-1:0]  m_wpld,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [B_PLD_W-1:0]  s_bpld,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [B_PLD_W-1:0]  m_bpld,
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [AR_PLD_W-1:0] s_arpld,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [AR_PLD_W-1:0] m_arpld,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [R_PLD_W-1:0]  s_rpld,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [R_PLD_W-1:0]  m_rpld,
    output logic                idle
);

    logic aw_empty, w_empty, b_empty, ar_empty, r_empty;

    hs_bus_amba_slice_chan #(.MODE(AW_MODE), .PLD_W(AW_PLD_W)) u_aw (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(s_awvalid), .in_ready(s_awready), .in_pld(s_awpld),
        .out_valid(m_awvalid), .out_ready(m_awready), .out_pld(m_awpld),
        .empty(aw_empty)
    );

    hs_bus_amba_slice_chan #(.MODE(W_MODE), .PLD_W(W_PLD_W)) u_w (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(s_wvalid), .in_ready(s_wready), .in_pld(s_wpld),
        .out_valid(m_wvalid), .out_ready(m_wready), .out_pld(m_wpld),
        .empty(w_empty)
    );

    hs_bus_amba_slice_chan #(.MODE(B_MODE), .PLD_W(B_PLD_W)) u_b (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(m_bvalid), .in_ready(m_bready), .in_pld(m_bpld),
        .out_valid(s_bvalid), .out_ready(s_bready), .out_pld(s_bpld),
        .empty(b_empty)
    );

    hs_bus_amba_slice_chan #(.MODE(AR_MODE), .PLD_W(AR_PLD_W)) u_ar (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(s_arvalid), .in_ready(s_arready), .in_pld(s_arpld),
        .out_valid(m_arvalid), .out_ready(m_arready), .out_pld(m_arpld),
        .empty(ar_empty)
    );

    hs_bus_amba_slice_chan #(.MODE(R_MODE), .PLD_W(R_PLD_W)) u_r (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(m_rvalid), .in_ready(m_rready), .in_pld(m_rpld),
        .out_valid(s_rvalid), .out_ready(s_rready), .out_pld(s_rpld),
        .empty(r_empty)
    );

    // Bypass stages report empty permanently, so they never hold idle low.
    assign idle = aw_empty && w_empty && b_empty && ar_empty && r_empty;

endmodule

// File: tb/tb_hs_bus_amba_axilite_slice.sv
// Scoreboard bench for two slice instances covering all four stage modes.
// Slots 0-4 are AW,W,B,AR,R of dut_a (defaults); slots 5-9 the same of dut_b.
module tb_hs_bus_amba_axilite_slice;
    import hs_bus_amba_axilite_slice_pkg::*;

    localparam int NS   = 10;
    localparam int AW_W = 1 + 32 + 3 + 3;
    localparam int W_W  = 32 + 4 + 1;
    localparam int B_W  = 1 + 2 + 1;
    localparam int AR_W = 1 + 32 + 3 + 3;
    localparam int R_W  = 1 + 32 + 2 + 1 + 1;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic        in_vld  [NS];
    logic [63:0] in_pld  [NS];
    logic        out_rdy [NS];
    wire         in_rdy  [NS];
    wire         out_vld [NS];
    wire  [63:0] out_pld [NS];
    wire         idle_a, idle_b;

    int          vprob [NS];
    int          rprob [NS];
    bit          seqm  [NS];
    logic [63:0] base  [NS];
    int          gen   [NS];
    int          acc_cnt [NS];
    int          out_cnt [NS];
    int          rd_i  [NS];
    logic [63:0] exp_q [NS][$];

    int n_vec = 0;
    int n_err = 0;

    function automatic int pw(int s);
        case (s % 5)
            0:       return AW_W;
            1:       return W_W;
            2:       return B_W;
            3:       return AR_W;
            default: return R_W;
        endcase
    endfunction

    function automatic logic [63:0] mask(int s);
        return (64'd1 << pw(s)) - 64'd1;
    endfunction

    function automatic slice_mode_e mode_of(int s);
        case (s)
            0, 1, 3: return SLICE_FULL;
            2, 4, 8: return SLICE_FWD;
            5:       return SLICE_HALF;
            6:       return SLICE_BYPASS;
            default: return SLICE_FULL;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
        #2;
    endtask

    wire [AW_W-1:0] a_m_awpld, b_m_awpld;
    wire [W_W-1:0]  a_m_wpld,  b_m_wpld;
    wire [B_W-1:0]  a_s_bpld,  b_s_bpld;
    wire [AR_W-1:0] a_m_arpld, b_m_arpld;
    wire [R_W-1:0]  a_s_rpld,  b_s_rpld;

    assign out_pld[0] = 64'(a_m_awpld);
    assign out_pld[1] = 64'(a_m_wpld);
    assign out_pld[2] = 64'(a_s_bpld);
    assign out_pld[3] = 64'(a_m_arpld);
    assign out_pld[4] = 64'(a_s_rpld);
    assign out_pld[5] = 64'(b_m_awpld);
    assign out_pld[6] = 64'(b_m_wpld);
    assign out_pld[7] = 64'(b_s_bpld);
    assign out_pld[8] = 64'(b_m_arpld);
    assign out_pld[9] = 64'(b_s_rpld);

    hs_bus_amba_axilite_slice dut_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(in_vld[0]), .s_awready(in_rdy[0]), .s_awpld(in_pld[0][AW_W-1:0]),
        .m_awvalid(out_vld[0]), .m_awready(out_rdy[0]), .m_awpld(a_m_awpld),
        .s_wvalid(in_vld[1]), .s_wready(in_rdy[1]), .s_wpld(in_pld[1][W_W-1:0]),
        .m_wvalid(out_vld[1]), .m_wready(out_rdy[1]), .m_wpld(a_m_wpld),
        .s_bvalid(out_vld[2]), .s_bready(out_rdy[2]), .s_bpld(a_s_bpld),
        .m_bvalid(in_vld[2]), .m_bready(in_rdy[2]), .m_bpld(in_pld[2][B_W-1:0]),
        .s_arvalid(in_vld[3]), .s_arready(in_rdy[3]), .s_arpld(in_pld[3][AR_W-1:0]),
        .m_arvalid(out_vld[3]), .m_arready(out_rdy[3]), .m_arpld(a_m_arpld),
        .s_rvalid(out_vld[4]), .s_rready(out_rdy[4]), .s_rpld(a_s_rpld),
        .m_rvalid(in_vld[4]), .m_rready(in_rdy[4]), .m_rpld(in_pld[4][R_W-1:0]),
        .idle(idle_a)
    );

    hs_bus_amba_axilite_slice #(
        .AW_MODE(SLICE_HALF), .W_MODE(SLICE_BYPASS), .B_MODE(SLICE_FULL),
        .AR_MODE(SLICE_FWD), .R_MODE(SLICE_FULL)
    ) dut_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(in_vld[5]), .s_awready(in_rdy[5]), .s_awpld(in_pld[5][AW_W-1:0]),
        .m_awvalid(out_vld[5]), .m_awready(out_rdy[5]), .m_awpld(b_m_awpld),
        .s_wvalid(in_vld[6]), .s_wready(in_rdy[6]), .s_wpld(in_pld[6][W_W-1:0]),
        .m_wvalid(out_vld[6]), .m_wready(out_rdy[6]), .m_wpld(b_m_wpld),
        .s_bvalid(out_vld[7]), .s_bready(out_rdy[7]), .s_bpld(b_s_bpld),
        .m_bvalid(in_vld[7]), .m_bready(in_rdy[7]), .m_bpld(in_pld[7][B_W-1:0]),
        .s_arvalid(in_vld[8]), .s_arready(in_rdy[8]), .s_arpld(in_pld[8][AR_W-1:0]),
        .m_arvalid(out_vld[8]), .m_arready(out_rdy[8]), .m_arpld(b_m_arpld),
        .s_rvalid(out_vld[9]), .s_rready(out_rdy[9]), .s_rpld(b_s_rpld),
        .m_rvalid(in_vld[9]), .m_rready(in_rdy[9]), .m_rpld(in_pld[9][R_W-1:0]),
        .idle(idle_b)
    );

    for (genvar gs = 0; gs < NS; gs++) begin : g_slot
        // Source: holds a beat until accepted, records every accepted beat as expected output.
        initial begin : drv
            logic        took;
            int          last_gen;
            logic [63:0] nxt;
            took = 1'b0;
            last_gen = 0;
            nxt = '0;
            in_vld[gs] = 1'b0;
            in_pld[gs] = '0;
            out_rdy[gs] = 1'b0;
            forever begin
                @(posedge aclk);
                #1;
                if (gen[gs] != last_gen) begin
                    last_gen = gen[gs];
                    nxt = base[gs];
                end
                if (!aresetn) begin
                    in_vld[gs] = 1'b0;
                end else if (!in_vld[gs] || took) begin
                    if (int'($urandom_range(99)) < vprob[gs]) begin
                        in_vld[gs] = 1'b1;
                        if (seqm[gs]) begin
                            in_pld[gs] = nxt & mask(gs);
                            nxt = nxt + 64'd1;
                        end else begin
                            in_pld[gs] = {$urandom, $urandom} & mask(gs);
                        end
                    end else begin
                        in_vld[gs] = 1'b0;
                    end
                end
                out_rdy[gs] = int'($urandom_range(99)) < rprob[gs];
                took = 1'b0;
                @(negedge aclk);
                if (aresetn && in_vld[gs] && in_rdy[gs]) begin
                    exp_q[gs].push_back(in_pld[gs]);
                    acc_cnt[gs]++;
                    took = 1'b1;
                end
            end
        end

        // Sink monitor: compares each delivered beat with the next expected one.
        initial begin : mon
            logic        v, r, rst, st_v;
            logic [63:0] p, st_p;
            st_v = 1'b0;
            st_p = '0;
            forever begin
                @(negedge aclk);
                v = out_vld[gs];
                r = out_rdy[gs];
                p = out_pld[gs];
                rst = aresetn;
                #1;
                if (!rst) begin
                    rd_i[gs] = exp_q[gs].size();
                    st_v = 1'b0;
                end else begin
                    if (st_v) begin
                        check($sformatf("hold_valid[%0d]", gs), 64'(v), 64'd1);
                        check($sformatf("hold_pld[%0d]", gs), p, st_p);
                    end
                    if (v && r) begin
                        if (rd_i[gs] >= exp_q[gs].size()) begin
                            check($sformatf("unexpected_beat[%0d]", gs), p, 64'hx);
                        end else begin
                            check($sformatf("order[%0d]", gs), p, exp_q[gs][rd_i[gs]]);
                            rd_i[gs]++;
                            out_cnt[gs]++;
                        end
                    end
                    st_v = v && !r;
                    st_p = p;
                end
            end
        end
    end

    initial begin : main
        int a0;
        int oc [NS];
        int total;
        for (int s = 0; s < NS; s++) begin
            vprob[s] = 0;
            rprob[s] = 0;
            seqm[s] = 1'b1;
            base[s] = '0;
            gen[s] = 0;
            acc_cnt[s] = 0;
            out_cnt[s] = 0;
            rd_i[s] = 0;
        end

        // Reset state, then registered readies rise on the first edge after release.
        tick(3);
        for (int s = 0; s < NS; s++) begin
            check($sformatf("rst_valid[%0d]", s), 64'(out_vld[s]), 64'd0);
            if (mode_of(s) == SLICE_FULL || mode_of(s) == SLICE_HALF)
                check($sformatf("rst_ready[%0d]", s), 64'(in_rdy[s]), 64'd0);
        end
        check("rst_idle_a", 64'(idle_a), 64'd1);
        check("rst_idle_b", 64'(idle_b), 64'd1);
        aresetn = 1'b1;
        tick(1);
        for (int s = 0; s < NS; s++) begin
            if (mode_of(s) == SLICE_FULL || mode_of(s) == SLICE_HALF)
                check($sformatf("ready_rise[%0d]", s), 64'(in_rdy[s]), 64'd1);
            rprob[s] = 100;
        end

        // FULL stall: two beats accepted, third refused, head held.
        base[0] = 64'hA;
        gen[0]++;
        rprob[0] = 0;
        vprob[0] = 100;
        a0 = acc_cnt[0];
        tick(5);
        check("stall_accepts", 64'(acc_cnt[0] - a0), 64'd2);
        check("stall_ready", 64'(in_rdy[0]), 64'd0);
        check("stall_valid", 64'(out_vld[0]), 64'd1);
        check("stall_head", out_pld[0], 64'hA);
        check("stall_pending", in_pld[0], 64'hC);
        check("stall_idle_a", 64'(idle_a), 64'd0);
        vprob[0] = 0;
        rprob[0] = 100;
        tick(6);
        check("stall_drained", 64'(rd_i[0]), 64'(exp_q[0].size()));

        // Continuous streaming on every slot: latency then throughput.
        for (int s = 0; s < NS; s++) begin
            base[s] = 64'(s * 256 + 16);
            gen[s]++;
            vprob[s] = 100;
            rprob[s] = 100;
        end
        tick(1);
        for (int s = 0; s < NS; s++) begin
            check($sformatf("lat_first_cycle[%0d]", s), 64'(out_vld[s]), 64'(mode_of(s) == SLICE_BYPASS));
            if (mode_of(s) == SLICE_BYPASS)
                check($sformatf("lat0_pld[%0d]", s), out_pld[s], base[s] & mask(s));
        end
        tick(1);
        for (int s = 0; s < NS; s++) begin
            if (mode_of(s) != SLICE_BYPASS) begin
                check($sformatf("lat1_valid[%0d]", s), 64'(out_vld[s]), 64'd1);
                check($sformatf("lat1_pld[%0d]", s), out_pld[s], base[s] & mask(s));
            end
        end
        tick(8);
        for (int s = 0; s < NS; s++) oc[s] = out_cnt[s];
        tick(100);
        for (int s = 0; s < NS; s++)
            check($sformatf("throughput[%0d]", s), 64'(out_cnt[s] - oc[s]),
                  (mode_of(s) == SLICE_HALF) ? 64'd50 : 64'd100);
        for (int s = 0; s < NS; s++) vprob[s] = 0;
        tick(8);
        check("stream_idle_a", 64'(idle_a), 64'd1);
        check("stream_idle_b", 64'(idle_b), 64'd1);

        // Bypass channel is combinational and never affects idle.
        seqm[6] = 1'b0;
        vprob[6] = 50;
        rprob[6] = 50;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("byp_valid", 64'(out_vld[6]), 64'(in_vld[6]));
            check("byp_ready", 64'(in_rdy[6]), 64'(out_rdy[6]));
            if (in_vld[6]) check("byp_pld", out_pld[6], in_pld[6]);
            check("byp_idle_b", 64'(idle_b), 64'd1);
        end
        vprob[6] = 0;
        rprob[6] = 100;
        tick(4);

        // Reset mid-transfer with two beats parked in the FULL read-data stage.
        base[9] = 64'h55;
        gen[9]++;
        rprob[9] = 0;
        vprob[9] = 100;
        a0 = acc_cnt[9];
        tick(5);
        check("rr_buffered", 64'(acc_cnt[9] - a0), 64'd2);
        check("rr_idle_b_busy", 64'(idle_b), 64'd0);
        vprob[9] = 0;
        rprob[9] = 100;
        aresetn = 1'b0;
        #1;
        check("rr_valid_now", 64'(out_vld[9]), 64'd0);
        check("rr_ready_now", 64'(in_rdy[9]), 64'd0);
        check("rr_idle_now", 64'(idle_b), 64'd1);
        tick(2);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("rr_no_stale", 64'(out_vld[9]), 64'd0);
        end
        check("rr_ready_back", 64'(in_rdy[9]), 64'd1);

        // Random traffic with random backpressure on every channel.
        for (int s = 0; s < NS; s++) seqm[s] = 1'b0;
        for (int s = 0; s < NS; s++) oc[s] = out_cnt[s];
        for (int blk = 0; blk < 30; blk++) begin
            for (int s = 0; s < NS; s++) begin
                vprob[s] = 30 + int'($urandom_range(65));
                rprob[s] = 30 + int'($urandom_range(65));
            end
            tick(200);
        end
        for (int s = 0; s < NS; s++) begin
            vprob[s] = 0;
            rprob[s] = 100;
        end
        tick(20);
        total = 0;
        for (int s = 0; s < NS; s++) begin
            check($sformatf("drained[%0d]", s), 64'(rd_i[s]), 64'(exp_q[s].size()));
            total += out_cnt[s] - oc[s];
        end
        check("random_beats_enough", 64'(total >= 10000), 64'd1);
        check("final_idle_a", 64'(idle_a), 64'd1);
        check("final_idle_b", 64'(idle_b), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hs_bus_amba_axilite_slice.md
HS_BUS_AMBA_AXILITE_SLICE -- requirements
Module: hs_bus_amba_axilite_slice

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named aclk and aresetn.
REQ-002 Width parameters SHALL be ID_W_WIDTH=1, ID_R_WIDTH=1, ADDR_WIDTH=32, DATA_WIDTH=32, USER_DATA_WIDTH=1, USER_RESP_WIDTH=1, SUBSYSID_WIDTH=3, BRESP_WIDTH=2 and RRESP_WIDTH=2, each with the standard AXI5-Lite field meaning.
REQ-003 AW_MODE, default SLICE_FULL: slice mode of the write request channel.
REQ-004 W_MODE, default SLICE_FULL: slice mode of the write data channel.
REQ-005 B_MODE, default SLICE_FWD: slice mode of the write response channel.
REQ-006 AR_MODE, default SLICE_FULL: slice mode of the read request channel.
REQ-007 R_MODE, default SLICE_FWD: slice mode of the read data channel.
REQ-008 Ports SHALL be:
- aclk  input  1  clock.
- aresetn  input  1  async active-low reset.
- s_awvalid/s_awready/s_awpld  in/out/in  1/1/AW_PLD_W  upstream write request.
- m_awvalid/m_awready/m_awpld  out/in/out  1/1/AW_PLD_W  downstream write request.
- s_wvalid/s_wready/s_wpld  in/out/in  1/1/W_PLD_W  upstream write data.
- m_wvalid/m_wready/m_wpld  out/in/out  1/1/W_PLD_W  downstream write data.
- s_bvalid/s_bready/s_bpld  out/in/out  1/1/B_PLD_W  upstream write response.
- m_bvalid/m_bready/m_bpld  in/out/in  1/1/B_PLD_W  downstream write response.
- s_arvalid/s_arready/s_arpld  in/out/in  1/1/AR_PLD_W  upstream read request.
- m_arvalid/m_arready/m_arpld  out/in/out  1/1/AR_PLD_W  downstream read request.
- s_rvalid/s_rready/s_rpld  out/in/out  1/1/R_PLD_W  upstream read data.
- m_rvalid/m_rready/m_rpld  in/out/in  1/1/R_PLD_W  downstream read data.
- idle  output  1  all slices empty.
REQ-009 Each *_PLD_W SHALL be the packed concatenation of all AXI5-Lite fields of that channel, in package-defined order.

Function
REQ-010 Request channels (AW, W, AR) SHALL flow s_ to m_; response channels (B, R) SHALL flow m_ to s_.
REQ-011 SLICE_BYPASS SHALL pass valid, ready and payload combinationally with 0 latency and no storage.
REQ-012 SLICE_FWD SHALL register valid and payload with 1-cycle latency; ready_in = !full || ready_out (combinational); full throughput.
REQ-013 SLICE_FULL SHALL be a 2-entry skid buffer with all outputs registered, 1-cycle latency and full throughput.
  - States: EMPTY, ONE, TWO.
  - EMPTY->ONE on push.
  - ONE->TWO on push without pop.
  - ONE->EMPTY on pop without push.
  - TWO->ONE on pop.
  - ready_in = (state != TWO).
REQ-014 SLICE_HALF SHALL be a 1-entry buffer with ready_in = empty and valid_out = full; 50% maximum throughput.
REQ-015 In every mode, payloads SHALL leave in arrival order, with no loss and no duplication.
REQ-016 Simultaneous push and pop in state ONE SHALL remain in ONE, with the new beat replacing the popped one.
REQ-017 Payload registers SHALL load only on push, and output payload SHALL stay stable while valid_out && !ready_out.
REQ-018 idle SHALL be 1 iff every non-bypass slice is EMPTY; bypass channels SHALL be ignored.

Reset
REQ-019 While aresetn=0:
  - all valid outputs SHALL be 0;
  - all registered ready outputs SHALL be 0;
  - every state SHALL be EMPTY;
  - idle SHALL be 1.
REQ-020 Registered ready outputs SHALL rise on the first aclk edge after aresetn deasserts.
REQ-021 Payload registers SHALL NOT be reset.
REQ-022 Reset asserted mid-transfer SHALL discard buffered beats immediately.

Configuration
REQ-023 With HS_AXILITE_SLICE_ASSERT_EN defined, the module SHALL include:
  - valid-hold and payload-stable assertions on both sides of every channel;
  - a handshake cover per channel;
  - an elaboration error on an illegal *_MODE.
REQ-024 Without HS_AXILITE_SLICE_ASSERT_EN, no assertion or cover code SHALL be compiled and behaviour SHALL be identical.

Structure
REQ-025 Package hs_bus_amba_axilite_slice_pkg SHALL hold:
  - enum slice_mode_e (SLICE_BYPASS, SLICE_FWD, SLICE_FULL, SLICE_HALF);
  - per-channel payload width functions;
  - field ordering constants.
REQ-026 The per-channel behaviour SHALL be implemented in one sub-module, hs_bus_amba_slice_chan, parametrised by MODE and PLD_W and instantiated five times.

Verification
REQ-027 FULL mode, m_awready held 0, three pushes 0xA,0xB,0xC -> s_awready drops after second accept; m_awpld=0xA held; 0xC not accepted.
REQ-028 FULL mode, continuous valid, both readies 1 for 100 cycles -> 100 beats out in order, 1-cycle latency, no bubbles.
REQ-029 HALF mode, continuous valid, ready 1 -> exactly one beat per two cycles.
REQ-030 BYPASS mode -> m_wvalid/m_wpld equal s_wvalid/s_wpld in the same cycle; idle unaffected.
REQ-031 aresetn pulsed low with two R beats buffered -> s_rvalid=0 immediately, idle=1, no stale beat after release.
REQ-032 Random valid/ready backpressure on all five channels, 10k beats -> scoreboard order match, zero assertion failures with HS_AXILITE_SLICE_ASSERT_EN defined.
